// File: rtl/mem_access_pkg.sv
// Shared definitions for the MEM pipeline stage: memory op codes, FSM states
// and the pipeline's null values.
package mem_access_pkg;

   localparam logic [31:0] ZeroWord           = 32'h0000_0000;
   localparam logic        WriteEnable        = 1'b1;
   localparam logic        WriteDisable       = 1'b0;
   localparam logic [4:0]  NOPRegisterAddress = 5'b00000;

   localparam logic [3:0] MEM_NOP = 4'd0;
   localparam logic [3:0] MEM_LB  = 4'd1;
   localparam logic [3:0] MEM_LBU = 4'd2;
   localparam logic [3:0] MEM_LH  = 4'd3;
   localparam logic [3:0] MEM_LHU = 4'd4;
   localparam logic [3:0] MEM_LW  = 4'd5;
   localparam logic [3:0] MEM_SB  = 4'd6;
   localparam logic [3:0] MEM_SH  = 4'd7;
   localparam logic [3:0] MEM_SW  = 4'd8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DONE = 2'd2
   } state_t;

   function automatic logic is_load(input logic [3:0] op);
      return op inside {MEM_LB, MEM_LBU, MEM_LH, MEM_LHU, MEM_LW};
   endfunction

   function automatic logic is_store(input logic [3:0] op);
      return op inside {MEM_SB, MEM_SH, MEM_SW};
   endfunction

   function automatic logic is_mem_op(input logic [3:0] op);
      return is_load(op) || is_store(op);
   endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Big-endian lane steering: byte enables, replicated store data, extended load
// value and the misalignment flag for one memory op.
module mem_lane_align
   import mem_access_pkg::*;
(
   input  logic [3:0]  op,
   input  logic [1:0]  offset,
   input  logic [31:0] store_data,
   input  logic [31:0] rdata,
   output logic [3:0]  sel,
   output logic [31:0] wdata,
   output logic [31:0] load_value,
   output logic        misaligned
);

   logic [7:0]  lane_byte;
   logic [15:0] lane_half;
   logic [3:0]  byte_sel;
   logic [3:0]  half_sel;

   // Offset 0 is the most significant lane.
   always_comb begin
      case (offset)
         2'd0:    lane_byte = rdata[31:24];
         2'd1:    lane_byte = rdata[23:16];
         2'd2:    lane_byte = rdata[15:8];
         default: lane_byte = rdata[7:0];
      endcase
      lane_half = offset[1] ? rdata[15:0] : rdata[31:16];
      byte_sel  = 4'b1000 >> offset;
      half_sel  = offset[1] ? 4'b0011 : 4'b1100;
   end

   always_comb begin
      // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
      sel        = 4'b0000;
      wdata      = ZeroWord;
      load_value = rdata;
      misaligned = 1'b0;
      case (op)
         MEM_LB: begin
            sel        = byte_sel;
            load_value = {{24{lane_byte[7]}}, lane_byte};
         end
         MEM_LBU: begin
            sel        = byte_sel;
            load_value = {24'h0, lane_byte};
         end
         MEM_LH: begin
            sel        = half_sel;
            load_value = {{16{lane_half[15]}}, lane_half};
            misaligned = offset[0];
         end
         MEM_LHU: begin
            sel        = half_sel;
            load_value = {16'h0, lane_half};
            misaligned = offset[0];
         end
         MEM_LW: begin
            sel        = 4'b1111;
            misaligned = |offset;
         end
         MEM_SB: begin
            sel   = byte_sel;
            wdata = {4{store_data[7:0]}};
         end
         MEM_SH: begin
            sel        = half_sel;
            wdata      = {2{store_data[15:0]}};
            misaligned = offset[0];
         end
         MEM_SW: begin
            sel        = 4'b1111;
            wdata      = store_data;
            misaligned = |offset;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/mem_access.sv
// MEM pipeline stage: runs loads/stores over a req/ack bus, stalls the pipeline
// while a transaction is outstanding and forwards results toward write-back.
module mem_access
   import mem_access_pkg::*;
#(
   parameter int BUS_TIMEOUT = 16,
   parameter int TIMER_WIDTH = 5
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [4:0]  ex_write_reg_address_input,
   input  logic        ex_write_reg_enable_input,
   input  logic [31:0] ex_write_reg_data_input,
   input  logic [31:0] ex_hi_input,
   input  logic [31:0] ex_lo_input,
   input  logic        ex_whilo_input,
   input  logic [3:0]  ex_mem_op_input,
   input  logic [31:0] ex_mem_address_input,
   input  logic [31:0] ex_mem_store_data_input,
   input  logic [31:0] bus_rdata,
   input  logic        bus_ack,
   output logic        bus_req,
   output logic        bus_we,
   output logic [31:0] bus_addr,
   output logic [3:0]  bus_sel,
   output logic [31:0] bus_wdata,
   output logic [4:0]  mem_write_reg_address_output,
   output logic        mem_write_reg_enable_output,
   output logic [31:0] mem_write_reg_data_output,
   output logic [31:0] mem_hi_output,
   output logic [31:0] mem_lo_output,
   output logic        mem_whilo_output,
   output logic        stall_request,
   output logic        mem_error
);

   localparam logic [TIMER_WIDTH-1:0] TIMEOUT_LAST = TIMER_WIDTH'(BUS_TIMEOUT - 1);

   state_t                 state, next_state;
   logic [TIMER_WIDTH-1:0] timer;
   logic [31:0]            load_reg;
   logic                   aborted;
   logic [3:0]             lane_sel;
   logic [31:0]            lane_wdata;
   logic [31:0]            load_value;
   logic                   misaligned;
   logic                   issue;
   logic                   timeout;

   // Store lanes come from the live inputs; load extension uses the captured word.
   mem_lane_align u_lane_align (
      .op         (ex_mem_op_input),
      .offset     (ex_mem_address_input[1:0]),
      .store_data (ex_mem_store_data_input),
      .rdata      (load_reg),
      .sel        (lane_sel),
      .wdata      (lane_wdata),
      .load_value (load_value),
      .misaligned (misaligned)
   );

   assign issue   = (state == IDLE) && is_mem_op(ex_mem_op_input) && !misaligned;
   assign timeout = (state == WAIT) && !bus_ack && (timer == TIMEOUT_LAST);

   always_ff @(posedge clock) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (reset) state <= IDLE;
      else       state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (issue) next_state = WAIT;
         WAIT:    if (bus_ack || timeout) next_state = DONE;
         DONE:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // NOTE: the captured load word is reset with the bus registers so nothing stale reaches write-back.
   always_ff @(posedge clock) begin
      if (reset) begin
         timer     <= '0;
         bus_req   <= 1'b0;
         bus_we    <= 1'b0;
         bus_addr  <= ZeroWord;
         bus_sel   <= 4'b0000;
         bus_wdata <= ZeroWord;
         load_reg  <= ZeroWord;
         aborted   <= 1'b0;
      end else if (issue) begin
         timer     <= '0;
         bus_req   <= 1'b1;
         bus_we    <= is_store(ex_mem_op_input);
         bus_addr  <= {ex_mem_address_input[31:2], 2'b00};
         bus_sel   <= lane_sel;
         bus_wdata <= lane_wdata;
         aborted   <= 1'b0;
      end else if (state == WAIT) begin
         timer <= timer + 1'b1;
         if (bus_ack) begin
            load_reg <= bus_rdata;
            bus_req  <= 1'b0;
         end else if (timeout) begin
            bus_req <= 1'b0;
            aborted <= 1'b1;
         end
      end
   end

   always_comb begin
      mem_write_reg_address_output = ex_write_reg_address_input;
      mem_write_reg_enable_output  = ex_write_reg_enable_input;
      mem_write_reg_data_output    = ex_write_reg_data_input;
      mem_hi_output                = ex_hi_input;
      mem_lo_output                = ex_lo_input;
      mem_whilo_output             = ex_whilo_input;
      stall_request                = 1'b0;
      mem_error                    = 1'b0;
      if (reset) begin
         mem_write_reg_address_output = NOPRegisterAddress;
         mem_write_reg_enable_output  = WriteDisable;
         mem_write_reg_data_output    = ZeroWord;
         mem_hi_output                = ZeroWord;
         mem_lo_output                = ZeroWord;
         mem_whilo_output             = WriteDisable;
      end else begin
         case (state)
            IDLE: begin
               if (is_mem_op(ex_mem_op_input)) begin
                  if (misaligned) begin
                     mem_error                   = 1'b1;
                     mem_write_reg_enable_output = WriteDisable;
                  end else begin
                     stall_request = 1'b1;
                  end
               end
            end
            WAIT: begin
               stall_request = 1'b1;
               mem_error     = timeout;
            end
            DONE: begin
               if (is_load(ex_mem_op_input)) mem_write_reg_data_output = load_value;
               if (aborted) mem_write_reg_enable_output = WriteDisable;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: pass-through and misaligned vectors, a table of
// complete bus transactions, and hand sequences for timeout and reset-in-WAIT.
module tb_mem_access;
   import mem_access_pkg::*;

   localparam int BUS_TIMEOUT = 16;

   logic        clock = 1'b0;
   logic        reset;
   logic [4:0]  ex_write_reg_address_input;
   logic        ex_write_reg_enable_input;
   logic [31:0] ex_write_reg_data_input;
   logic [31:0] ex_hi_input;
   logic [31:0] ex_lo_input;
   logic        ex_whilo_input;
   logic [3:0]  ex_mem_op_input;
   logic [31:0] ex_mem_address_input;
   logic [31:0] ex_mem_store_data_input;
   logic [31:0] bus_rdata;
   logic        bus_ack;
   logic        bus_req;
   logic        bus_we;
   logic [31:0] bus_addr;
   logic [3:0]  bus_sel;
   logic [31:0] bus_wdata;
   logic [4:0]  mem_write_reg_address_output;
   logic        mem_write_reg_enable_output;
   logic [31:0] mem_write_reg_data_output;
   logic [31:0] mem_hi_output;
   logic [31:0] mem_lo_output;
   logic        mem_whilo_output;
   logic        stall_request;
   logic        mem_error;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clock = ~clock;

   mem_access #(.BUS_TIMEOUT(BUS_TIMEOUT), .TIMER_WIDTH(5)) dut (
      .clock                        (clock),
      .reset                        (reset),
      .ex_write_reg_address_input   (ex_write_reg_address_input),
      .ex_write_reg_enable_input    (ex_write_reg_enable_input),
      .ex_write_reg_data_input      (ex_write_reg_data_input),
      .ex_hi_input                  (ex_hi_input),
      .ex_lo_input                  (ex_lo_input),
      .ex_whilo_input               (ex_whilo_input),
      .ex_mem_op_input              (ex_mem_op_input),
      .ex_mem_address_input         (ex_mem_address_input),
      .ex_mem_store_data_input      (ex_mem_store_data_input),
      .bus_rdata                    (bus_rdata),
      .bus_ack                      (bus_ack),
      .bus_req                      (bus_req),
      .bus_we                       (bus_we),
      .bus_addr                     (bus_addr),
      .bus_sel                      (bus_sel),
      .bus_wdata                    (bus_wdata),
      .mem_write_reg_address_output (mem_write_reg_address_output),
      .mem_write_reg_enable_output  (mem_write_reg_enable_output),
      .mem_write_reg_data_output    (mem_write_reg_data_output),
      .mem_hi_output                (mem_hi_output),
      .mem_lo_output                (mem_lo_output),
      .mem_whilo_output             (mem_whilo_output),
      .stall_request                (stall_request),
      .mem_error                    (mem_error)
   );

   typedef struct {
      string       name;
      logic [3:0]  op;
      logic [31:0] addr;
      logic        exp_err;
      logic        exp_en;
   } idle_vec_t;

   typedef struct {
      string       name;
      logic [3:0]  op;
      logic [31:0] addr;
      logic [31:0] store_data;
      logic [31:0] rdata;
      int          ack_delay;
      logic [31:0] exp_addr;
      logic [3:0]  exp_sel;
      logic        exp_we;
      logic [31:0] exp_wdata;
      logic [31:0] exp_data;
      logic        exp_en;
   } txn_vec_t;

   idle_vec_t idle_vecs[6];
   txn_vec_t  txns[10];

   task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
      n_checks++;
      if (actual !== expected) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
      end
   endtask

   task automatic check_bit(input string name, input logic actual, input logic expected);
      n_checks++;
      if (actual !== expected) begin
         n_fail++;
         $display("FAIL %s: got %b, expected %b", name, actual, expected);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic drive_ex(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] sd,
                           input logic [4:0] dest, input logic en, input logic [31:0] data,
                           input logic whilo);
      ex_mem_op_input            = op;
      ex_mem_address_input       = addr;
      ex_mem_store_data_input    = sd;
      ex_write_reg_address_input = dest;
      ex_write_reg_enable_input  = en;
      ex_write_reg_data_input    = data;
      ex_hi_input                = 32'h1111_1111;
      ex_lo_input                = 32'h2222_2222;
      ex_whilo_input             = whilo;
   endtask

   task automatic run_txn(input txn_vec_t t);
      tick();
      drive_ex(t.op, t.addr, t.store_data, 5'd9, t.exp_en, 32'hA5A5_0000, 1'b0);
      #1;
      check_bit({t.name, " issue stall"}, stall_request, 1'b1);
      check_bit({t.name, " issue err"}, mem_error, 1'b0);
      tick();
      check_bit({t.name, " bus_req"}, bus_req, 1'b1);
      check({t.name, " bus_addr"}, bus_addr, t.exp_addr);
      check({t.name, " bus_sel"}, {28'h0, bus_sel}, {28'h0, t.exp_sel});
      check_bit({t.name, " bus_we"}, bus_we, t.exp_we);
      if (t.exp_we) check({t.name, " bus_wdata"}, bus_wdata, t.exp_wdata);
      for (int c = 0; c <= t.ack_delay; c++) begin
         if (c == t.ack_delay) begin
            bus_ack   = 1'b1;
            bus_rdata = t.rdata;
         end
         #1;
         check_bit($sformatf("%s wait%0d stall", t.name, c), stall_request, 1'b1);
         check_bit($sformatf("%s wait%0d err", t.name, c), mem_error, 1'b0);
         tick();
         bus_ack   = 1'b0;
         bus_rdata = 32'h0BAD_F00D;
      end
      #1;
      check_bit({t.name, " done stall"}, stall_request, 1'b0);
      check_bit({t.name, " done bus_req"}, bus_req, 1'b0);
      check({t.name, " done data"}, mem_write_reg_data_output, t.exp_data);
      check_bit({t.name, " done en"}, mem_write_reg_enable_output, t.exp_en);
      check({t.name, " done addr"}, {27'h0, mem_write_reg_address_output}, 32'd9);
      check({t.name, " done hi"}, mem_hi_output, 32'h1111_1111);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      idle_vecs[0] = '{"nop pass", MEM_NOP, 32'h0000_0000, 1'b0, 1'b1};
      idle_vecs[1] = '{"lw 0x102", MEM_LW,  32'h0000_0102, 1'b1, 1'b0};
      idle_vecs[2] = '{"lh 0x201", MEM_LH,  32'h0000_0201, 1'b1, 1'b0};
      idle_vecs[3] = '{"lhu 0x3",  MEM_LHU, 32'h0000_0003, 1'b1, 1'b0};
      idle_vecs[4] = '{"sw 0x303", MEM_SW,  32'h0000_0303, 1'b1, 1'b0};
      idle_vecs[5] = '{"sh 0x301", MEM_SH,  32'h0000_0301, 1'b1, 1'b0};

      //            name        op       addr          store data    rdata         dly  exp addr      sel      we    wdata         data          en
      txns[0] = '{"lw 0x100",  MEM_LW,  32'h0000_0100, 32'h0,        32'hDEAD_BEEF, 1, 32'h0000_0100, 4'b1111, 1'b0, 32'h0,        32'hDEAD_BEEF, 1'b1};
      txns[1] = '{"lb 0x203",  MEM_LB,  32'h0000_0203, 32'h0,        32'h1122_33F0, 0, 32'h0000_0200, 4'b0001, 1'b0, 32'h0,        32'hFFFF_FFF0, 1'b1};
      txns[2] = '{"lbu 0x203", MEM_LBU, 32'h0000_0203, 32'h0,        32'h1122_33F0, 2, 32'h0000_0200, 4'b0001, 1'b0, 32'h0,        32'h0000_00F0, 1'b1};
      txns[3] = '{"sh 0x302",  MEM_SH,  32'h0000_0302, 32'h0000_BEEF, 32'h0,        0, 32'h0000_0300, 4'b0011, 1'b1, 32'hBEEF_BEEF, 32'hA5A5_0000, 1'b0};
      txns[4] = '{"lh 0x200",  MEM_LH,  32'h0000_0200, 32'h0,        32'h8001_1234, 0, 32'h0000_0200, 4'b1100, 1'b0, 32'h0,        32'hFFFF_8001, 1'b1};
      txns[5] = '{"lhu 0x202", MEM_LHU, 32'h0000_0202, 32'h0,        32'h8001_9234, 1, 32'h0000_0200, 4'b0011, 1'b0, 32'h0,        32'h0000_9234, 1'b1};
      txns[6] = '{"sb 0x401",  MEM_SB,  32'h0000_0401, 32'h0000_00AB, 32'h0,        0, 32'h0000_0400, 4'b0100, 1'b1, 32'hABAB_ABAB, 32'hA5A5_0000, 1'b0};
      txns[7] = '{"sw 0x500",  MEM_SW,  32'h0000_0500, 32'h1234_5678, 32'h0,        3, 32'h0000_0500, 4'b1111, 1'b1, 32'h1234_5678, 32'hA5A5_0000, 1'b0};
      txns[8] = '{"lb 0x601",  MEM_LB,  32'h0000_0601, 32'h0,        32'h117F_2233, 0, 32'h0000_0600, 4'b0100, 1'b0, 32'h0,        32'h0000_007F, 1'b1};
      txns[9] = '{"lw ack@to", MEM_LW,  32'h0000_0900, 32'h0,        32'hCAFE_F00D, BUS_TIMEOUT - 1, 32'h0000_0900, 4'b1111, 1'b0, 32'h0, 32'hCAFE_F00D, 1'b1};

      reset     = 1'b1;
      bus_ack   = 1'b0;
      bus_rdata = 32'h0;
      drive_ex(MEM_LW, 32'h0000_0100, 32'h0, 5'd5, 1'b1, 32'h0000_1234, 1'b1);
      tick();
      tick();
      check_bit("reset bus_req", bus_req, 1'b0);
      check("reset bus_addr", bus_addr, 32'h0);
      check("reset bus_sel", {28'h0, bus_sel}, 32'h0);
      check_bit("reset stall", stall_request, 1'b0);
      check_bit("reset err", mem_error, 1'b0);
      check("reset data", mem_write_reg_data_output, 32'h0);
      check_bit("reset en", mem_write_reg_enable_output, 1'b0);
      check_bit("reset whilo", mem_whilo_output, 1'b0);
      drive_ex(MEM_NOP, 32'h0, 32'h0, 5'd5, 1'b1, 32'h0000_1234, 1'b1);
      reset = 1'b0;

      foreach (idle_vecs[i]) begin
         tick();
         drive_ex(idle_vecs[i].op, idle_vecs[i].addr, 32'h0, 5'd5, 1'b1, 32'h0000_1234, 1'b1);
         #1;
         check_bit({idle_vecs[i].name, " err"}, mem_error, idle_vecs[i].exp_err);
         check_bit({idle_vecs[i].name, " en"}, mem_write_reg_enable_output, idle_vecs[i].exp_en);
         check_bit({idle_vecs[i].name, " stall"}, stall_request, 1'b0);
         check({idle_vecs[i].name, " data"}, mem_write_reg_data_output, 32'h0000_1234);
         check({idle_vecs[i].name, " addr"}, {27'h0, mem_write_reg_address_output}, 32'd5);
         check_bit({idle_vecs[i].name, " whilo"}, mem_whilo_output, 1'b1);
         check({idle_vecs[i].name, " lo"}, mem_lo_output, 32'h2222_2222);
         tick();
         check_bit({idle_vecs[i].name, " no bus_req"}, bus_req, 1'b0);
         check_bit({idle_vecs[i].name, " still idle"}, stall_request, 1'b0);
      end

      foreach (txns[i]) run_txn(txns[i]);

      // Timeout: no ack for BUS_TIMEOUT WAIT cycles.
      tick();
      drive_ex(MEM_LW, 32'h0000_0700, 32'h0, 5'd9, 1'b1, 32'hA5A5_0000, 1'b0);
      #1;
      check_bit("timeout issue stall", stall_request, 1'b1);
      tick();
      for (int c = 0; c < BUS_TIMEOUT; c++) begin
         check_bit($sformatf("timeout wait%0d err", c), mem_error, c == BUS_TIMEOUT - 1);
         check_bit($sformatf("timeout wait%0d stall", c), stall_request, 1'b1);
         tick();
      end
      check_bit("timeout done en", mem_write_reg_enable_output, 1'b0);
      check_bit("timeout done err", mem_error, 1'b0);
      check_bit("timeout done stall", stall_request, 1'b0);
      check_bit("timeout done bus_req", bus_req, 1'b0);
      tick();
      drive_ex(MEM_NOP, 32'h0, 32'h0, 5'd9, 1'b1, 32'h0000_4321, 1'b0);
      #1;
      check_bit("timeout back idle stall", stall_request, 1'b0);
      check_bit("timeout back idle en", mem_write_reg_enable_output, 1'b1);
      tick();
      check_bit("timeout no reissue", bus_req, 1'b0);

      // Reset asserted while waiting for the bus.
      drive_ex(MEM_LW, 32'h0000_0800, 32'h0, 5'd5, 1'b1, 32'h0000_1234, 1'b1);
      tick();
      check_bit("rst-wait bus_req before", bus_req, 1'b1);
      reset = 1'b1;
      #1;
      check_bit("rst-wait forced stall", stall_request, 1'b0);
      check("rst-wait forced data", mem_write_reg_data_output, 32'h0);
      check("rst-wait forced addr", {27'h0, mem_write_reg_address_output}, 32'h0);
      check("rst-wait forced hi", mem_hi_output, 32'h0);
      tick();
      check_bit("rst-wait bus_req after", bus_req, 1'b0);
      check("rst-wait bus_addr after", bus_addr, 32'h0);
      drive_ex(MEM_NOP, 32'h0, 32'h0, 5'd5, 1'b1, 32'h0000_1234, 1'b1);
      reset     = 1'b0;
      bus_ack   = 1'b1;
      bus_rdata = 32'h5555_AAAA;
      #1;
      check_bit("late ack stall", stall_request, 1'b0);
      check_bit("late ack err", mem_error, 1'b0);
      check("late ack data", mem_write_reg_data_output, 32'h0000_1234);
      tick();
      bus_ack = 1'b0;
      check_bit("late ack bus_req", bus_req, 1'b0);
      check_bit("late ack still idle", stall_request, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
